// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address-width computation and parameter legality check,
// used by the single-clock and dual-clock FIFOs.
package fifo_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic bit params_ok(input int depth, input int af_level,
                                    input int ae_level, input int fwft);
      bit ok;
      ok = (depth >= 4) && ((depth & (depth - 1)) == 0);
      ok = ok && (af_level >= 1) && (af_level <= depth - 1);
      ok = ok && (ae_level >= 0) && (ae_level <= depth - 2);
      ok = ok && ((fwft == 0) || (fwft == 1));
      return ok;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, combinational read.
// Contents are intentionally not reset.
module fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // storage write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, overflow and
// underflow pulses, and optional first-word-fall-through output.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 64,
   parameter  int AF_LEVEL = 56,
   parameter  int AE_LEVEL = 8,
   parameter  int FWFT     = 0,
   localparam int ADDR_W   = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] buf_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] buf_out,
   output logic              buf_empty,
   output logic              buf_full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   fifo_counter,
   output logic              overflow,
   output logic              underflow
);

   localparam int CNT_W = ADDR_W + 1;

   if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_param_err
      $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL/FWFT");
   end

   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              overflow_r;
   logic              underflow_r;
   logic              wr_acc_s;
   logic              rd_acc_s;
   logic              empty_s;
   logic              full_s;
   logic [DATA_W-1:0] ram_rdata_s;

   assign empty_s  = (count_r == {CNT_W{1'b0}});
   assign full_s   = (count_r == CNT_W'(DEPTH));
   assign wr_acc_s = wr_en & ~full_s;
   assign rd_acc_s = rd_en & ~empty_s;

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc_s),
      .waddr (wr_ptr_r),
      .wdata (buf_in),
      .raddr (rd_ptr_r),
      .rdata (ram_rdata_s)
   );

   // pointers, occupancy and error pulses; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {ADDR_W{1'b0}};
         rd_ptr_r    <= {ADDR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         overflow_r  <= wr_en & full_s;
         underflow_r <= rd_en & empty_s;
      end
   end

   if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] rd_data_r;

      // registered read: head word captured only when a read is accepted
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
         end else if (rd_acc_s) begin
            rd_data_r <= ram_rdata_s;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end

      assign buf_out = rd_data_r;
   end else begin : g_fwft
      // head word shown directly; meaningless while empty
      assign buf_out = ram_rdata_s;
   end

   assign buf_empty    = empty_s;
   assign buf_full     = full_s;
   assign almost_empty = (count_r <= CNT_W'(AE_LEVEL));
   assign almost_full  = (count_r >= CNT_W'(AF_LEVEL));
   assign fifo_counter = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule
